// File: rtl/glitch_cmd_sender_if.sv
// Command request, uart_tx byte and uart_rx byte signals of the glitcher command sender.
interface glitch_cmd_sender_if;
    logic        start_i;
    logic [2:0]  cmd_i;
    logic [15:0] arg_i;
    logic        busy_o;
    logic        done_o;
    logic        hello_ok_o;
    logic        hello_err_o;
    logic [7:0]  tx_data_o;
    logic        tx_en_o;
    logic        tx_busy_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;

    modport slave (
        input  start_i, cmd_i, arg_i, tx_busy_i, rx_data_i, rx_valid_i,
        output busy_o, done_o, hello_ok_o, hello_err_o, tx_data_o, tx_en_o
    );

    modport master (
        output start_i, cmd_i, arg_i, tx_busy_i, rx_data_i, rx_valid_i,
        input  busy_o, done_o, hello_ok_o, hello_err_o, tx_data_o, tx_en_o
    );
endinterface

// File: rtl/glitch_cmd_sender.sv
// Host-side glitcher command encoder: frames one command onto uart_tx and, for 'h',
// checks the "Hello\n" reply arriving on uart_rx.
module glitch_cmd_sender #(
    parameter int unsigned RESP_TIMEOUT = 50000
) (
    input logic                 clk,
    input logic                 rst,
    glitch_cmd_sender_if.slave  bus
);
    localparam int unsigned CntW = $clog2(RESP_TIMEOUT) + 1;
    localparam logic [2:0]  CmdH = 3'd7;

    typedef enum logic [2:0] {
        StIdle, StLoad, StSend, StGuard, StWaitTx, StHelloRx, StFinish
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      cmd_q, cmd_d;
    logic [15:0]     arg_q, arg_d;
    logic [1:0]      idx_q, idx_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            ok_q, ok_d;
    logic            err_q, err_d;
    logic [2:0]      match_q, match_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tx_en;
    logic            three_byte, two_byte;
    logic [1:0]      last_idx;
    logic [7:0]      frame_byte;

    function automatic logic [7:0] opcode(input logic [2:0] c);
        case (c)
            3'd0:    return 8'h64;
            3'd1:    return 8'h77;
            3'd2:    return 8'h6E;
            3'd3:    return 8'h73;
            3'd4:    return 8'h72;
            3'd5:    return 8'h74;
            3'd6:    return 8'h61;
            default: return 8'h68;
        endcase
    endfunction

    function automatic logic [7:0] hello_byte(input logic [2:0] i);
        case (i)
            3'd0:    return 8'h48;
            3'd1:    return 8'h65;
            3'd2:    return 8'h6C;
            3'd3:    return 8'h6C;
            3'd4:    return 8'h6F;
            default: return 8'h0A;
        endcase
    endfunction

    // d,s,r carry a 16-bit argument; w,n an 8-bit one; t,a,h are opcode only.
    assign three_byte = (cmd_q == 3'd0) || (cmd_q == 3'd3) || (cmd_q == 3'd4);
    assign two_byte   = (cmd_q == 3'd1) || (cmd_q == 3'd2);
    assign last_idx   = three_byte ? 2'd2 : (two_byte ? 2'd1 : 2'd0);

    always_comb begin
        frame_byte = arg_q[7:0];
        case (idx_q)
            2'd0:    frame_byte = opcode(cmd_q);
            2'd1:    frame_byte = three_byte ? arg_q[15:8] : arg_q[7:0];
            default: frame_byte = arg_q[7:0];
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        arg_d     = arg_q;
        idx_d     = idx_q;
        tx_data_d = tx_data_q;
        ok_d      = ok_q;
        err_d     = err_q;
        match_d   = match_q;
        cnt_d     = cnt_q;
        tx_en     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start_i) begin
                    cmd_d   = bus.cmd_i;
                    arg_d   = bus.arg_i;
                    idx_d   = 2'd0;
                    ok_d    = 1'b0;
                    err_d   = 1'b0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                tx_data_d = frame_byte;
                state_d   = StSend;
            end
            StSend: begin
                if (!bus.tx_busy_i) begin
                    tx_en   = 1'b1;
                    state_d = StGuard;
                end
            end
            // uart_tx raises busy a cycle after the strobe; do not trust it yet.
            StGuard: state_d = StWaitTx;
            StWaitTx: begin
                if (!bus.tx_busy_i) begin
                    if (idx_q != last_idx) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = StLoad;
                    end else if (cmd_q == CmdH) begin
                        match_d = 3'd0;
                        cnt_d   = '0;
                        state_d = StHelloRx;
                    end else begin
                        state_d = StFinish;
                    end
                end
            end
            StHelloRx: begin
                // A byte arriving on the expiry cycle wins over the timeout.
                if (bus.rx_valid_i) begin
                    if (bus.rx_data_i != hello_byte(match_q)) begin
                        err_d   = 1'b1;
                        state_d = StFinish;
                    end else if (match_q == 3'd5) begin
                        ok_d    = 1'b1;
                        state_d = StFinish;
                    end else begin
                        match_d = match_q + 3'd1;
                    end
                end else if (cnt_q == CntW'(RESP_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StFinish;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cmd_q     <= 3'd0;
            arg_q     <= 16'h0000;
            idx_q     <= 2'd0;
            tx_data_q <= 8'h00;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            match_q   <= 3'd0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            arg_q     <= arg_d;
            idx_q     <= idx_d;
            tx_data_q <= tx_data_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
            match_q   <= match_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.busy_o      = (state_q != StIdle);
    assign bus.done_o      = (state_q == StFinish);
    assign bus.hello_ok_o  = ok_q;
    assign bus.hello_err_o = err_q;
    assign bus.tx_data_o   = tx_data_q;
    assign bus.tx_en_o     = tx_en;
endmodule
